gpu_fill_engine: RTL

Hardware rectangle-fill engine for the bitmap graphics GPU. It accepts a fill command (base byte address, row stride, width, height, fill byte) and runs it as a sequence of register-bus writes into the graphics core's CPU register interface at 0xC100. This offloads framebuffer clears and solid-rectangle draws from the 6502. It sits upstream of the graphics core, behind the bus arbiter that shares the register port with the CPU. It is mode-agnostic: it fills whole bytes, so the caller converts pixel coordinates to byte addresses for 1, 2 or 4 BPP.

---
 rtl/gpu_fill_engine_if.sv | 25 ++
 rtl/gpu_fill_engine.sv | 134 +++++++++++++
 2 files changed

// File: rtl/gpu_fill_engine_if.sv
// Command and register-bus bundle for gpu_fill_engine.
// master = the fill engine; slave = the command source plus the bus arbiter.
interface gpu_fill_engine_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [14:0] cmd_base;
  logic [7:0]  cmd_stride;
  logic [7:0]  cmd_width;
  logic [7:0]  cmd_height;
  logic [7:0]  cmd_fill;
  logic [3:0]  bus_addr;
  logic [7:0]  bus_data;
  logic        bus_we;
  logic        bus_grant;

  modport master (
    input  cmd_valid, cmd_base, cmd_stride, cmd_width, cmd_height, cmd_fill, bus_grant,
    output cmd_ready, bus_addr, bus_data, bus_we
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_stride, cmd_width, cmd_height, cmd_fill, bus_grant,
    input  cmd_ready, bus_addr, bus_data, bus_we
  );
endinterface

// File: rtl/gpu_fill_engine.sv
// Rectangle fill engine: turns a fill command into register writes to the graphics core.
// Define GPU_FILL_BURST_EN to set the address once per row (needs core auto-increment).
module gpu_fill_engine #(
  parameter logic [3:0] ADDR_LO_OFS = 4'h0,
  parameter logic [3:0] ADDR_HI_OFS = 4'h1,
  parameter logic [3:0] DATA_OFS    = 4'h2
) (
  input  logic               clk_cpu,
  input  logic               rst_n,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  gpu_fill_engine_if.master  fe
);

`ifdef GPU_FILL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, SET_LO, SET_HI, WR_DATA, NEXT_ROW, FINISH
  } state_t;

  state_t      state, state_next;
  logic [14:0] row_addr, cur_addr;
  logic [7:0]  col_cnt, row_cnt;
  logic [7:0]  width_q, stride_q, fill_q;
  logic [14:0] next_row_addr;

  assign next_row_addr = row_addr + {7'd0, stride_q};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:
        if (fe.cmd_valid)
          state_next = (fe.cmd_width == 8'd0 || fe.cmd_height == 8'd0) ? FINISH : SET_LO;
      SET_LO:
        if (fe.bus_grant) state_next = SET_HI;
      SET_HI:
        if (fe.bus_grant) state_next = WR_DATA;
      WR_DATA:
        if (fe.bus_grant) begin
          if (col_cnt == 8'd1) state_next = NEXT_ROW;
          else                 state_next = BURST ? WR_DATA : SET_LO;
        end
      NEXT_ROW:
        state_next = (row_cnt == 8'd1) ? FINISH : SET_LO;
      FINISH:
        state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
    // Abort overrides everything, including a final write completing this cycle.
    if (abort && state != IDLE) state_next = IDLE;
  end

  // Outputs decode only registered state, so bus_grant never reaches bus_we.
  always_comb begin
    fe.bus_we   = 1'b0;
    fe.bus_addr = 4'h0;
    fe.bus_data = 8'h00;
    unique case (state)
      SET_LO: begin
        fe.bus_we   = 1'b1;
        fe.bus_addr = ADDR_LO_OFS;
        fe.bus_data = cur_addr[7:0];
      end
      SET_HI: begin
        fe.bus_we   = 1'b1;
        fe.bus_addr = ADDR_HI_OFS;
        fe.bus_data = {1'b0, cur_addr[14:8]};
      end
      WR_DATA: begin
        fe.bus_we   = 1'b1;
        fe.bus_addr = DATA_OFS;
        fe.bus_data = fill_q;
      end
      default: ;
    endcase
    fe.cmd_ready = (state == IDLE);
    busy         = (state != IDLE);
    done         = (state == FINISH);
  end

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      row_addr <= '0;
      cur_addr <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      width_q  <= '0;
      stride_q <= '0;
      fill_q   <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (fe.cmd_valid) begin
            row_addr <= fe.cmd_base;
            cur_addr <= fe.cmd_base;
            col_cnt  <= fe.cmd_width;
            row_cnt  <= fe.cmd_height;
            width_q  <= fe.cmd_width;
            stride_q <= fe.cmd_stride;
            fill_q   <= fe.cmd_fill;
          end
        WR_DATA:
          if (fe.bus_grant) begin
            col_cnt <= col_cnt - 8'd1;
            if (!BURST) cur_addr <= cur_addr + 15'd1;
          end
        NEXT_ROW: begin
          row_addr <= next_row_addr;
          cur_addr <= next_row_addr;
          row_cnt  <= row_cnt - 8'd1;
          col_cnt  <= width_q;
        end
        default: ;
      endcase
    end
  end

endmodule
